// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock-enable generator.
// Each channel toggles slow_clk every div+1 cycles and pulses tick on each rise.
// Divisors are changed through a shared valid/ready config port. A new divisor
// takes effect on the target channel's next toggle edge, or on the next edge if
// that channel is disabled, so the channel never sees a shortened half period.
// Optional feature macro: CLK_DIV_SYNC_EN adds the sync_restart input, which
// phase-aligns all enabled channels.
module clk_div_bank #(
    parameter int CHANNELS    = 4,
    parameter int DIV_WIDTH   = 20,
    parameter int DEFAULT_DIV = 1_000_000,
    localparam int CW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CW-1:0]        cfg_chan,
    input  logic [DIV_WIDTH-1:0] cfg_div,
`ifdef CLK_DIV_SYNC_EN
    input  logic                 sync_restart,
`endif
    output logic                 cfg_err,
    output logic [CHANNELS-1:0]  slow_clk,
    output logic [CHANNELS-1:0]  tick
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [CW:0]          NUM_CH  = (CW+1)'(CHANNELS);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                             state;
    state_t                             state_next;
    logic [CHANNELS-1:0][DIV_WIDTH-1:0] cnt;
    logic [CHANNELS-1:0][DIV_WIDTH-1:0] div;
    logic [CW-1:0]                      pend_chan;
    logic [DIV_WIDTH-1:0]               pend_div;
    logic                               accept;
    logic                               bad_chan;
    logic                               apply;
    logic [CHANNELS-1:0]                at_div;
    logic                               restart;

`ifdef CLK_DIV_SYNC_EN
    assign restart = sync_restart;
`else
    assign restart = 1'b0;
`endif

    assign cfg_ready = (state == IDLE);

    // Flag every channel whose counter has reached its divisor (its toggle edge when enabled).
    always_comb begin
        at_div = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            at_div[i] = (cnt[i] == div[i]);
        end
    end

    // Config FSM decode: accept or reject requests in IDLE, release the pending divisor at a safe edge.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        bad_chan   = 1'b0;
        apply      = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    if ({1'b0, cfg_chan} >= NUM_CH) begin
                        bad_chan = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = PENDING;
                    end
                end
            end
            PENDING: begin
                // The old-divisor toggle still completes on this edge; the new value governs the next half.
                if (!en[pend_chan] || at_div[pend_chan]) begin
                    apply      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Config FSM state, the latched request and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_err   <= 1'b0;
            pend_chan <= '0;
            pend_div  <= '0;
        end else begin
            state   <= state_next;
            cfg_err <= bad_chan;
            if (accept) begin
                pend_chan <= cfg_chan;
                pend_div  <= cfg_div;
            end
        end
    end

    // Per-channel divisor registers, written only when a pending request is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= {CHANNELS{DEF_DIV}};
        end else if (apply) begin
            div[pend_chan] <= pend_div;
        end
    end

    // Channel counters: a disabled channel clears, then restart, then normal counting toward div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            slow_clk <= '0;
            tick     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!en[i] || restart) begin
                    cnt[i]      <= '0;
                    slow_clk[i] <= 1'b0;
                    tick[i]     <= 1'b0;
                end else if (at_div[i]) begin
                    cnt[i]      <= '0;
                    slow_clk[i] <= ~slow_clk[i];
                    tick[i]     <= ~slow_clk[i];
                end else begin
                    cnt[i]      <= cnt[i] + 1'b1;
                    tick[i]     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank with three channels and a default divisor of 3.
// A behavioural model schedules each channel's toggles as absolute edge numbers.
module tb_clk_div_bank;

    localparam int CH  = 3;
    localparam int DW  = 8;
    localparam int DEF = 3;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] en = '0;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_chan = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          sync_restart = 1'b0;
    wire           cfg_ready;
    wire           cfg_err;
    wire  [CH-1:0] slow_clk;
    wire  [CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    clk_div_bank #(
        .CHANNELS(CH),
        .DIV_WIDTH(DW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan),
        .cfg_div(cfg_div),
`ifdef CLK_DIV_SYNC_EN
        .sync_restart(sync_restart),
`endif
        .cfg_err(cfg_err),
        .slow_clk(slow_clk),
        .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: channel state is the level plus the absolute edge number of the next toggle.
    int            edge_n = 0;
    bit            m_run[CH];
    int            m_next[CH];
    int            m_div[CH];
    logic [CH-1:0] m_slow = '0;
    logic [CH-1:0] m_tick = '0;
    bit            m_pend = 1'b0;
    bit            m_err = 1'b0;
    int            m_pch = 0;
    int            m_pdiv = 0;
    bit            tp[CH];
    int            old_div[CH];
    bit            was_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0;
            m_slow = '0;
            m_tick = '0;
            m_pend = 1'b0;
            m_err  = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_run[i]  = 1'b0;
                m_next[i] = 0;
                m_div[i]  = DEF;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < CH; i++) begin
                old_div[i] = m_div[i];
                tp[i] = en[i] && (m_run[i] ? (edge_n == m_next[i]) : (m_div[i] == 0));
            end
            was_pend = m_pend;
            m_err = 1'b0;
            if (was_pend && (!en[m_pch] || tp[m_pch])) begin
                m_div[m_pch] = m_pdiv;
                m_pend = 1'b0;
            end
            if (!was_pend && cfg_valid) begin
                if (int'(cfg_chan) >= CH) begin
                    m_err = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_pch  = int'(cfg_chan);
                    m_pdiv = int'(cfg_div);
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!en[i] || sync_restart) begin
                    m_slow[i] = 1'b0;
                    m_tick[i] = 1'b0;
                    m_run[i]  = 1'b0;
                end else begin
                    if (!m_run[i]) begin
                        m_run[i]  = 1'b1;
                        m_next[i] = edge_n + old_div[i];
                    end
                    if (edge_n == m_next[i]) begin
                        m_tick[i] = ~m_slow[i];
                        m_slow[i] = ~m_slow[i];
                        m_next[i] = edge_n + m_div[i] + 1;
                    end else begin
                        m_tick[i] = 1'b0;
                    end
                end
            end
        end
    end

    wire  [2*CH+1:0] obs = {cfg_err, cfg_ready, tick, slow_clk};
    logic [2*CH+1:0] expv;
    always_comb expv = {m_err, ~m_pend, m_tick, m_slow};

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if ({slow_clk, tick} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {slow_clk, tick});
        end
        checks++;
        if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg: got ready=%b err=%b expected ready=1 err=0", cfg_ready, cfg_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_ch0();
        en = 3'b001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL basic_model k=%0d: got %b expected %b", k, obs, expv);
            end
            checks++;
            if (slow_clk[0] !== 1'(((k / 4) % 2)) || tick[0] !== (k % 8 == 4)) begin
                errors++;
                $display("FAIL basic_ch0 k=%0d: got slow=%b tick=%b expected slow=%0d tick=%0d",
                         k, slow_clk[0], tick[0], (k / 4) % 2, (k % 8 == 4));
            end
        end
    endtask

    task automatic test_cfg_div0();
        bit   seen_ready;
        logic prev;
        en = 3'b011;
        repeat ($urandom_range(6, 1)) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL div0_pre: got %b expected %b", obs, expv);
            end
        end
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_div   = 8'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL div0_pending: got ready=%b expected 0", cfg_ready);
        end
        seen_ready = 1'b0;
        for (int k = 0; k < 10 && !seen_ready; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL div0_wait: got %b expected %b", obs, expv);
            end
            seen_ready = (cfg_ready === 1'b1);
        end
        checks++;
        if (!seen_ready) begin
            errors++;
            $display("FAIL div0_apply_timeout: got ready=%b expected 1 within 10 cycles", cfg_ready);
        end
        for (int k = 0; k < 6; k++) begin
            prev = slow_clk[1];
            @(negedge clk);
            checks++;
            if (slow_clk[1] === prev || obs !== expv) begin
                errors++;
                $display("FAIL div0_toggle: got %b (prev ch1 %b) expected %b", obs, prev, expv);
            end
        end
    endtask

    task automatic test_cfg_err();
        cfg_valid = 1'b1;
        cfg_chan  = 2'd3;
        cfg_div   = 8'd7;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_pulse: got err=%b ready=%b expected err=1 ready=1", cfg_err, cfg_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv || cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_after: got %b expected %b", obs, expv);
            end
        end
    endtask

    task automatic test_en_drop();
        bit high;
        en[2] = 1'b1;
        high = 1'b0;
        for (int k = 0; k < 12 && !high; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL en_drop_run: got %b expected %b", obs, expv);
            end
            high = (slow_clk[2] === 1'b1);
        end
        checks++;
        if (!high) begin
            errors++;
            $display("FAIL en_drop_rise_timeout: got slow2=%b expected 1", slow_clk[2]);
        end
        en[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (slow_clk[2] !== 1'b0 || tick[2] !== 1'b0) begin
                errors++;
                $display("FAIL en_drop_cleared: got slow=%b tick=%b expected 0 0", slow_clk[2], tick[2]);
            end
        end
        en[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (slow_clk[2] !== (k >= 4) || tick[2] !== (k == 4) || obs !== expv) begin
                errors++;
                $display("FAIL en_reenable k=%0d: got %b expected %b", k, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", k, obs, expv);
            end
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(7) == 0) en[i] = ~en[i];
            end
            cfg_valid = ($urandom_range(3) == 0);
            cfg_chan  = CW'($urandom_range(3));
            cfg_div   = DW'($urandom_range(5));
`ifdef CLK_DIV_SYNC_EN
            sync_restart = ($urandom_range(15) == 0);
`endif
        end
        @(negedge clk);
        cfg_valid    = 1'b0;
        sync_restart = 1'b0;
    endtask

    task automatic test_async_reset();
        bit got_tick;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        en = 3'b001;
        got_tick = 1'b0;
        for (int k = 0; k < 12 && !got_tick; k++) begin
            @(negedge clk);
            got_tick = (tick[0] === 1'b1);
        end
        checks++;
        if (!got_tick) begin
            errors++;
            $display("FAIL async_tick_timeout: got tick0=%b expected 1", tick[0]);
        end
        cfg_valid = 1'b1;
        cfg_chan  = 2'd0;
        cfg_div   = 8'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_pending: got ready=%b expected 0", cfg_ready);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({slow_clk, tick} !== '0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs, {2'b01, {2*CH{1'b0}}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (slow_clk[0] !== (k >= 4 && k < 8) || obs !== expv) begin
                errors++;
                $display("FAIL async_default_div k=%0d: got %b expected %b", k, obs, expv);
            end
        end
    endtask

`ifdef CLK_DIV_SYNC_EN
    task automatic test_sync();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        en = '0;
        cfg_valid = 1'b1;
        cfg_chan  = 2'd0;
        cfg_div   = 8'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        en = 3'b001;
        @(negedge clk);
        en = 3'b011;
        repeat (5) @(negedge clk);
        sync_restart = 1'b1;
        @(negedge clk);
        sync_restart = 1'b0;
        checks++;
        if (slow_clk[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL sync_clear: got slow=%b tick=%b expected 00 00", slow_clk[1:0], tick[1:0]);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (slow_clk[0] !== 1'(((k / 2) % 2)) || slow_clk[1] !== (k >= 4) || obs !== expv) begin
                errors++;
                $display("FAIL sync_align k=%0d: got %b expected %b", k, obs, expv);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_ch0();
        test_cfg_div0();
        test_cfg_err();
        test_en_drop();
        test_random();
        test_async_reset();
`ifdef CLK_DIV_SYNC_EN
        test_sync();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
